// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Brief    : Instruction-fetch stage: PC register, imem request handshake,
//            one-entry skid buffer and IF/ID pipeline register.
// Revision : 1.0  initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] new_pc,
    input  logic        id_stall,
    input  logic        if_flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic        fetch_busy
);

    localparam logic [0:0] S_REQ  = 1'b0;
    localparam logic [0:0] S_HELD = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        req_en_q;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d;
    logic        bubble;
    logic [31:0] new_pc_al;
    logic        unused_pc_bits;

    assign new_pc_al      = {new_pc[31:2], 2'b00};
    assign unused_pc_bits = ^new_pc[1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_REQ;
            req_en_q     <= 1'b0;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            redir_pc_q   <= 32'h0;
            hold_pc_q    <= 32'h0;
            hold_instr_q <= 32'h0;
            id_pc_q      <= 32'h0;
            id_instr_q   <= NOP_INSTR;
            id_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_en_q     <= 1'b1;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            redir_pc_q   <= redir_pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            id_valid_q   <= id_valid_d;
        end
    end

    // Nothing moves until the first edge after reset release, when the
    // request line first goes high.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        redir_pc_d   = redir_pc_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        id_valid_d   = id_valid_q;
        bubble       = 1'b0;
        if (req_en_q) begin
            case (state_q)
                S_REQ: begin
                    if (imem_ready) begin
                        if (if_flush) begin
                            bubble = 1'b1;
                            pc_d   = new_pc_al;
                            kill_d = 1'b0;
                        end else if (kill_q) begin
                            bubble = 1'b1;
                            pc_d   = redir_pc_q;
                            kill_d = 1'b0;
                        end else if (id_stall) begin
                            hold_pc_d    = pc_q;
                            hold_instr_d = imem_rdata;
                            state_d      = S_HELD;
                        end else begin
                            id_pc_d    = pc_q;
                            id_instr_d = imem_rdata;
                            id_valid_d = 1'b1;
                            pc_d       = new_pc_al;
                        end
                    end else if (if_flush) begin
                        // Address must stay stable; remember the target and
                        // drop the in-flight response when it arrives.
                        kill_d     = 1'b1;
                        redir_pc_d = new_pc_al;
                        bubble     = 1'b1;
                    end else if (!id_stall) begin
                        bubble = 1'b1;
                    end
                end
                S_HELD: begin
                    if (if_flush) begin
                        bubble  = 1'b1;
                        pc_d    = new_pc_al;
                        state_d = S_REQ;
                    end else if (!id_stall) begin
                        id_pc_d    = hold_pc_q;
                        id_instr_d = hold_instr_q;
                        id_valid_d = 1'b1;
                        pc_d       = new_pc_al;
                        state_d    = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
        if (bubble) begin
            id_pc_d    = 32'h0;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end
    end

    always_comb begin
        imem_req   = req_en_q && (state_q == S_REQ);
        imem_addr  = pc_q;
        fetch_busy = imem_req && !imem_ready;
    end

    assign pc_out   = pc_q;
    assign id_pc    = id_pc_q;
    assign id_instr = id_instr_q;
    assign id_valid = id_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Brief    : Directed self-checking bench for if_fetch_stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch_stage;

    logic        clk;
    logic        rstn;
    logic [31:0] new_pc;
    logic        id_stall;
    logic        if_flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        fetch_busy;

    logic        use_tgt;
    logic [31:0] tgt;
    int          n_tests;
    int          n_fail;

    if_fetch_stage dut (
        .clk        (clk),
        .rstn       (rstn),
        .new_pc     (new_pc),
        .id_stall   (id_stall),
        .if_flush   (if_flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc_out     (pc_out),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
        .id_valid   (id_valid),
        .fetch_busy (fetch_busy)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return ~a;
    endfunction

    // Environment: next-PC unit and memory data path.
    assign new_pc     = use_tgt ? tgt : pc_out + 32'd4;
    assign imem_rdata = word_at(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic stl, input logic fl,
                         input logic ut, input logic [31:0] t);
        @(negedge clk);
        imem_ready = rdy;
        id_stall   = stl;
        if_flush   = fl;
        use_tgt    = ut;
        tgt        = t;
        #1;
    endtask

    initial begin
        #10000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0; n_fail = 0;
        rstn = 1'b0; imem_ready = 1'b0; id_stall = 1'b0; if_flush = 1'b0;
        use_tgt = 1'b0; tgt = 32'h0;

        @(negedge clk); #1;
        chk("rst_req",    {31'h0, imem_req}, 32'h0);
        chk("rst_pc",     pc_out,   32'h3000);
        chk("rst_idpc",   id_pc,    32'h0);
        chk("rst_instr",  id_instr, 32'h0);
        chk("rst_valid",  {31'h0, id_valid}, 32'h0);
        #1 rstn = 1'b1; imem_ready = 1'b1;
        #1 chk("rel_req_low", {31'h0, imem_req}, 32'h0);

        // Zero-wait streaming
        drive(1, 0, 0, 0, 0);
        chk("zw_req0",   {31'h0, imem_req}, 32'h1);
        chk("zw_addr0",  imem_addr, 32'h3000);
        chk("zw_busy0",  {31'h0, fetch_busy}, 32'h0);
        chk("zw_valid0", {31'h0, id_valid}, 32'h0);
        drive(1, 0, 0, 0, 0);
        chk("zw_addr1",  imem_addr, 32'h3004);
        chk("zw_idpc1",  id_pc, 32'h3000);
        chk("zw_instr1", id_instr, word_at(32'h3000));
        chk("zw_valid1", {31'h0, id_valid}, 32'h1);
        // Stall three cycles at 0x3008
        drive(1, 1, 0, 0, 0);
        chk("zw_addr2",  imem_addr, 32'h3008);
        chk("zw_idpc2",  id_pc, 32'h3004);
        drive(1, 1, 0, 0, 0);
        chk("st_req1",   {31'h0, imem_req}, 32'h0);
        chk("st_idpc1",  id_pc, 32'h3004);
        drive(1, 1, 0, 0, 0);
        chk("st_idpc2",  id_pc, 32'h3004);
        chk("st_valid2", {31'h0, id_valid}, 32'h1);
        drive(1, 0, 0, 0, 0);
        chk("st_req3",   {31'h0, imem_req}, 32'h0);
        chk("st_pc3",    pc_out, 32'h3008);
        // Release: held instruction enters IF/ID, fetch resumes at 0x300C
        drive(1, 1'b0, 1, 1, 32'h3040);
        chk("rl_idpc",   id_pc, 32'h3008);
        chk("rl_instr",  id_instr, word_at(32'h3008));
        chk("rl_addr",   imem_addr, 32'h300C);
        // Flush (with ready) issued above
        drive(1, 0, 0, 0, 0);
        chk("fl_valid",  {31'h0, id_valid}, 32'h0);
        chk("fl_idpc",   id_pc, 32'h0);
        chk("fl_addr",   imem_addr, 32'h3040);
        // Latency 3 on 0x3044, flush in wait cycle 1
        drive(0, 0, 1, 1, 32'h3100);
        chk("tg_idpc",   id_pc, 32'h3040);
        chk("tg_valid",  {31'h0, id_valid}, 32'h1);
        chk("lw_addr1",  imem_addr, 32'h3044);
        chk("lw_busy1",  {31'h0, fetch_busy}, 32'h1);
        drive(0, 0, 0, 0, 0);
        chk("lw_addr2",  imem_addr, 32'h3044);
        chk("lw_valid2", {31'h0, id_valid}, 32'h0);
        chk("lw_busy2",  {31'h0, fetch_busy}, 32'h1);
        drive(1, 0, 0, 0, 0);
        chk("lw_addr3",  imem_addr, 32'h3044);
        chk("lw_busy3",  {31'h0, fetch_busy}, 32'h0);
        // Killed response dropped; redirect target requested with latency 3
        drive(0, 0, 0, 0, 0);
        chk("kl_addr",   imem_addr, 32'h3100);
        chk("kl_valid",  {31'h0, id_valid}, 32'h0);
        drive(0, 0, 0, 0, 0);
        chk("kl_busy",   {31'h0, fetch_busy}, 32'h1);
        chk("kl_valid2", {31'h0, id_valid}, 32'h0);
        drive(1, 0, 0, 0, 0);
        chk("kl_addr3",  imem_addr, 32'h3100);
        chk("kl_valid3", {31'h0, id_valid}, 32'h0);
        // Stall into S_HELD at 0x3104, then flush from S_HELD
        drive(1, 1, 0, 0, 0);
        chk("tg2_idpc",  id_pc, 32'h3100);
        chk("tg2_instr", id_instr, word_at(32'h3100));
        chk("tg2_addr",  imem_addr, 32'h3104);
        drive(1, 1, 1, 1, 32'h3200);
        chk("hf_req",    {31'h0, imem_req}, 32'h0);
        chk("hf_idpc",   id_pc, 32'h3100);
        drive(1, 0, 0, 0, 0);
        chk("hf_valid",  {31'h0, id_valid}, 32'h0);
        chk("hf_idpc2",  id_pc, 32'h0);
        chk("hf_addr",   imem_addr, 32'h3200);
        chk("hf_req2",   {31'h0, imem_req}, 32'h1);
        // Mid-wait asynchronous reset
        drive(0, 1, 0, 0, 0);
        chk("ar_idpc",   id_pc, 32'h3200);
        chk("ar_valid",  {31'h0, id_valid}, 32'h1);
        chk("ar_addr",   imem_addr, 32'h3204);
        #6 rstn = 1'b0;
        #1;
        chk("ar_req",    {31'h0, imem_req}, 32'h0);
        chk("ar_pc",     pc_out, 32'h3000);
        chk("ar_valid0", {31'h0, id_valid}, 32'h0);
        chk("ar_idpc0",  id_pc, 32'h0);
        chk("ar_busy",   {31'h0, fetch_busy}, 32'h0);
        drive(1, 0, 0, 0, 0);
        #1 rstn = 1'b1;
        drive(1, 0, 0, 0, 0);
        chk("ar_req1",   {31'h0, imem_req}, 32'h1);
        chk("ar_addr1",  imem_addr, 32'h3000);
        drive(1, 0, 0, 0, 0);
        chk("ar_idpc1",  id_pc, 32'h3000);
        chk("ar_valid1", {31'h0, id_valid}, 32'h1);
        chk("ar_addr2",  imem_addr, 32'h3004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
